// File: rtl/gmii_axis_packer.sv
// GMII receive byte stream to AXI4-Stream beat packer with optional routing header,
// overflow-safe frame termination and a first-word-fall-through beat FIFO.
module gmii_axis_packer #(
  parameter int         DATA_W     = 64,
  parameter int         FIFO_DEPTH = 16,
  parameter bit         HDR_EN     = 1'b1,
  parameter logic [3:0] NODE_ID    = 4'b0001,
  parameter logic [3:0] ETH_TYPE   = 4'b0001
) (
  input  logic                          gmii_rx_clk,
  input  logic                          rst,
  input  logic                          gmii_rx_dv,
  input  logic                          gmii_rx_er,
  input  logic [7:0]                    gmii_rxd,
  output logic                          axis_tvalid,
  output logic [DATA_W-1:0]             axis_tdata,
  output logic [DATA_W/8-1:0]           axis_tkeep,
  output logic                          axis_tlast,
  output logic                          axis_tuser,
  input  logic                          axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   frm_cnt,
  output logic [15:0]                   err_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int CW    = $clog2(BYTES) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int EW    = DATA_W + BYTES + 2;
  localparam logic [CW-1:0] FULL_CNT  = CW'(BYTES);
  localparam logic [CW-1:0] START_CNT = HDR_EN ? CW'(2) : CW'(1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

  // S_DROP holds a completed beat that could not be pushed; S_SKIP discards a whole frame.
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_SKIP} state_t;
  state_t state;

  logic [DATA_W-1:0] asm_data;
  logic [DATA_W-1:0] start_word;
  logic [CW-1:0]     asm_cnt;
  logic              asm_err;
  logic              asm_full;
  logic              term_pend;
  logic [BYTES-1:0]  keep_fill;

  logic push_req, push_last, push_user, push_ok;
  logic pop, full, drop_new, pop_good, pop_bad;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [EW-1:0]     rd_word;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;

  assign asm_full = (asm_cnt == FULL_CNT);
  assign full     = (level == DEPTH_L);

  // Handshake: a beat transfers on every edge where axis_tvalid && axis_tready; while
  // axis_tvalid is high and axis_tready is low the head beat is held unchanged.
  assign pop      = axis_tvalid && axis_tready;
  assign push_ok  = push_req && (!full || pop);
  assign pop_good = pop && axis_tlast && !axis_tuser;
  assign pop_bad  = pop && axis_tlast && axis_tuser;
  assign drop_new = (state == S_IDLE) && gmii_rx_dv && term_pend && !push_ok;

  always_comb begin
    keep_fill = '0;
    for (int i = 0; i < BYTES; i++) keep_fill[i] = (CW'(i) < asm_cnt);
  end

  always_comb begin
    start_word = '0;
    if (HDR_EN) begin
      start_word[7:0]  = {NODE_ID, ETH_TYPE};
      start_word[15:8] = gmii_rxd;
    end else begin
      start_word[7:0]  = gmii_rxd;
    end
  end

  // A held terminator is the only push source while it is pending.
  always_comb begin
    push_req  = 1'b0;
    push_last = 1'b0;
    push_user = 1'b0;
    if (term_pend) begin
      push_req  = 1'b1;
      push_last = 1'b1;
      push_user = 1'b1;
    end else begin
      case (state)
        S_RECV: begin
          if (gmii_rx_dv) begin
            push_req = asm_full;
          end else begin
            push_req  = 1'b1;
            push_last = 1'b1;
            push_user = asm_err;
          end
        end
        S_DROP: begin
          if (!gmii_rx_dv) begin
            push_req  = 1'b1;
            push_last = 1'b1;
            push_user = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= {asm_data, keep_fill, push_last, push_user};
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state     <= gmii_rx_dv ? S_SKIP : S_IDLE;
      asm_data  <= '0;
      asm_cnt   <= '0;
      asm_err   <= 1'b0;
      term_pend <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frm_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level   <= level + LW'(push_ok) - LW'(pop);
      frm_cnt <= frm_cnt + 16'(pop_good);
      err_cnt <= err_cnt + 16'(pop_bad) + 16'(drop_new);
      if (term_pend && push_ok) term_pend <= 1'b0;

      case (state)
        S_IDLE: begin
          if (gmii_rx_dv) begin
            if (drop_new) begin
              state <= S_SKIP;
            end else begin
              asm_data <= start_word;
              asm_cnt  <= START_CNT;
              asm_err  <= gmii_rx_er;
              state    <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (gmii_rx_dv) begin
            if (asm_full) begin
              if (push_ok) begin
                asm_data <= {{(DATA_W-8){1'b0}}, gmii_rxd};
                asm_cnt  <= CW'(1);
                asm_err  <= asm_err | gmii_rx_er;
              end else begin
                state <= S_DROP;
              end
            end else begin
              for (int i = 0; i < BYTES; i++)
                if (CW'(i) == asm_cnt) asm_data[8*i +: 8] <= gmii_rxd;
              asm_cnt <= asm_cnt + 1'b1;
              asm_err <= asm_err | gmii_rx_er;
            end
          end else begin
            state <= S_IDLE;
            if (!push_ok) term_pend <= 1'b1;
          end
        end
        S_DROP: begin
          if (!gmii_rx_dv) begin
            state <= S_IDLE;
            if (!push_ok) term_pend <= 1'b1;
          end
        end
        default: begin
          if (!gmii_rx_dv) state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_word     = mem[rd_ptr];
  assign axis_tvalid = (level != '0);
  assign {axis_tdata, axis_tkeep, axis_tlast, axis_tuser} = axis_tvalid ? rd_word : '0;
  assign fifo_level  = level;

endmodule

// File: doc/gmii_axis_packer.md
# gmii_axis_packer

Parametrised GMII-byte to AXI4-Stream packer for the Ethernet receive path. It packs an 8-bit GMII frame into DATA_W-bit beats and can prepend a one-byte routing header. It marks the true end of frame with tlast and a partial tkeep, buffers beats in an internal FIFO under downstream back-pressure, and flags errored or truncated frames on tuser. It runs in the GMII receive clock domain; any clock-domain crossing is done by a separate async FIFO downstream.

## Interface
- DATA_W, 64: output beat width in bits; legal values 32, 64, 128; BYTES = DATA_W/8.
- FIFO_DEPTH, 16: beat FIFO depth; power of two, 4..256.
- HDR_EN, 1: 1 = insert header byte {NODE_ID, ETH_TYPE} in lane 0 of the first beat.
- NODE_ID, 4'b0001: node identifier, header bits [7:4].
- ETH_TYPE, 4'b0001: traffic type, header bits [3:0].
- gmii_rx_clk  in  1  single clock, 125 MHz.
- rst  in  1  synchronous, active-high reset.
- gmii_rx_dv  in  1  GMII data valid.
- gmii_rx_er  in  1  GMII receive error.
- gmii_rxd  in  8  GMII data.
- axis_tvalid  out  1  beat valid.
- axis_tdata  out  DATA_W  beat data; lane i is bits [8i+7:8i].
- axis_tkeep  out  BYTES  byte enables, contiguous from lane 0.
- axis_tlast  out  1  last beat of frame.
- axis_tuser  out  1  frame bad; meaningful only with tlast.
- axis_tready  in  1  downstream ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  beats held in the FIFO.
- frm_cnt  out  16  frames emitted with tuser=0; wraps.
- err_cnt  out  16  frames emitted with tuser=1, plus frames dropped whole; wraps.

## Operation
- Reset (rst=1 at an edge) clears the FIFO, assembly register, flags and counters. Outputs after reset: tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, fifo_level=0, frm_cnt=0, err_cnt=0. Reset mid-frame discards the partial frame. Bytes still arriving under that dv are ignored until dv falls.
- Packing: the k-th payload byte goes to lane (k+HDR_EN) mod BYTES. With HDR_EN=1, the header and payload byte 0 are written on the same edge.
- Unused lanes of a partial beat are 0. tkeep has ones for filled lanes only.
- Completed beat: it is held in the assembly register with a pending flag. At the next edge:
  - if dv=1, push it with tlast=0 and write the new byte to lane 0;
  - if dv=0, push it with tlast=1.
- Partial beat at dv fall: push with tlast=1 and tkeep covering the filled lanes.
- gmii_rx_er=1 on any dv=1 cycle sets a frame-error flag. That frame's tlast beat carries tuser=1.
- A push succeeds if the FIFO is not full, or if a pop happens on the same edge.
- Overflow (a push fails):
  - hold the assembly beat and set the drop flag;
  - discard all further bytes of the frame;
  - at dv fall, set the held beat to tlast=1, tuser=1;
  - push it on the first edge the FIFO has space.
  - The downstream therefore always sees a terminated frame.
- A new frame that starts while a terminator is still pending is dropped whole. err_cnt increments by 1 for it.
- Counters update on the pop edge of a tlast beat: frm_cnt if tuser=0, err_cnt if tuser=1.
- Output is first-word-fall-through. A beat pops when tvalid && tready. tdata, tkeep, tlast and tuser stay stable while tvalid && !tready.

## Timing
- Push edge to tvalid: 1 cycle. With an empty FIFO, tvalid rises in the cycle after the push edge.
- Non-final beat: pushed on the edge sampling the first byte of the next beat, i.e. 1 cycle after its last lane is written.
- Final beat: pushed on the edge sampling dv=0. tlast is visible 2 cycles after the edge sampling the frame's last byte.
- Throughput: one push per BYTES cycles at most; one pop per cycle.
- fifo_level changes by +1 on a push, -1 on a pop, and 0 when both happen on the same edge.
- Back-to-back frames are legal: one dv=0 cycle between frames is enough.

## Test plan
- 64-byte frame, DATA_W=64, HDR_EN=0, tready=1 -> 8 beats with tkeep=FF. Only beat 8 has tlast=1. tuser=0, frm_cnt=1.
- 61-byte frame, HDR_EN=1, header 8'h11 -> beat 0 lane 0 = 8'h11. 8 beats total; last beat tkeep=8'h3F, tlast=1.
- 1-byte frame, DATA_W=32, HDR_EN=0 -> single beat, tkeep=4'h1, tlast=1, tdata[31:8]=0.
- tready=0 throughout, FIFO_DEPTH=4, 100-byte frame -> exactly 4 beats accepted, then a terminator with tlast=1, tuser=1. With tready=1 afterwards: 5 beats drain, err_cnt=1.
- gmii_rx_er=1 on byte 10 of a 40-byte frame -> last beat tuser=1 and err_cnt=1; frame length is unchanged.
- rst=1 for 1 cycle mid-frame -> all outputs at their reset values. The rest of that frame is ignored; the next frame packs correctly.
